// File: rtl/imager_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imager_pkg
//  Purpose  : Shared imager constants, serializer state encoding and helpers.
//  Revision : 1.0
// ============================================================================
package imager_pkg;

  localparam int C_MASK_DES_L = 18;
  localparam int C_NUM_ROWS   = 160;
  localparam int C_MAX_PATT   = 128;
  localparam int C_ADDR_W     = 15;

  // One-hot encoding; any illegal code recovers to ST_IDLE.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_FETCH = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_ram.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_ram
//  Purpose  : Simple dual-port mask pattern RAM, registered read, read-first.
//  Revision : 1.0
// ============================================================================
module pattern_ram #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 20480
) (
  input  logic              CLK_HS,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge CLK_HS) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/mask_pattern_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : mask_pattern_streamer
//  Purpose  : Serializes one stored mask pattern, MSB-first, per STREAM burst.
//  Revision : 1.0
// ============================================================================
module mask_pattern_streamer
  import imager_pkg::*;
#(
  parameter int C_MASK_DES_L = imager_pkg::C_MASK_DES_L,
  parameter int C_NUM_ROWS   = imager_pkg::C_NUM_ROWS,
  parameter int C_MAX_PATT   = imager_pkg::C_MAX_PATT,
  parameter int C_ADDR_W     = imager_pkg::C_ADDR_W
) (
  input  logic                    CLK_HS,
  input  logic                    RESET,
  input  logic                    STREAM,
  input  logic [31:0]             NUM_PAT,
  input  logic                    PAT_RST,
  input  logic                    WR_EN,
  input  logic [C_ADDR_W-1:0]     WR_ADDR,
  input  logic [C_MASK_DES_L-1:0] WR_DATA,
  input  logic                    ERR_CLR,
  output logic                    MASK_SDATA,
  output logic                    MASK_LOAD,
  output logic [15:0]             PAT_IDX,
  output logic                    BUSY,
  output logic                    ERR_SHORT
);

  localparam int                C_BIT_W    = clog2(C_MASK_DES_L);
  localparam int                C_ROW_W    = clog2(C_NUM_ROWS);
  localparam logic [C_BIT_W-1:0] c_bit_last = C_BIT_W'(C_MASK_DES_L - 1);
  localparam logic [C_BIT_W-1:0] c_bit_pre  = C_BIT_W'(C_MASK_DES_L - 2);
  localparam logic [C_ROW_W-1:0] c_row_last = C_ROW_W'(C_NUM_ROWS - 1);

  state_t                  r_state, w_state_nxt;
  logic                    r_sync1, r_sync2, r_sync3, r_rise, r_fall;
  logic [C_ADDR_W-1:0]     r_addr, w_rd_addr, w_base;
  logic [C_MASK_DES_L-1:0] r_shreg, w_rd_data;
  logic [C_BIT_W-1:0]      r_bit;
  logic [C_ROW_W-1:0]      r_row;
  logic                    r_sdata, r_load, r_busy, r_err, r_rst_pend;
  logic [15:0]             r_pat, w_pat_next;
  logic [31:0]             w_eff, w_pat_p1;
  logic                    w_rd_en, w_start, w_load, w_next_row, w_shift;
  logic                    w_finish, w_abort, w_advance;

  pattern_ram #(
    .DATA_W (C_MASK_DES_L),
    .ADDR_W (C_ADDR_W),
    .DEPTH  (C_MAX_PATT * C_NUM_ROWS)
  ) u_ram (
    .CLK_HS    (CLK_HS),
    .i_wr_en   (WR_EN),
    .i_wr_addr (WR_ADDR),
    .i_wr_data (WR_DATA),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // STREAM crosses in from CLKMPRE: 2-FF synchronizer, then edge register.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= STREAM;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_rise  <= r_sync2 & ~r_sync3;
      r_fall  <= ~r_sync2 & r_sync3;
    end
  end

  assign w_base     = C_ADDR_W'(int'(r_pat) * C_NUM_ROWS);
  assign w_eff      = (NUM_PAT == 32'd0) ? 32'd1 :
                      (NUM_PAT > 32'(C_MAX_PATT)) ? 32'(C_MAX_PATT) : NUM_PAT;
  assign w_pat_p1   = {16'd0, r_pat} + 32'd1;
  assign w_pat_next = (w_pat_p1 >= w_eff) ? 16'd0 : r_pat + 16'd1;

  always_ff @(posedge CLK_HS) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_rd_addr   = w_base;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_next_row  = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rise) begin
          w_rd_en     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (r_fall) begin
          w_abort     = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_fall) begin
          w_abort     = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_bit == c_bit_last) begin
          if (r_row == c_row_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_load     = 1'b1;
            w_next_row = 1'b1;
          end
        end else begin
          w_shift = 1'b1;
          // Prefetch one bit early so the next row arrives with no gap.
          if (r_bit == c_bit_pre && r_row != c_row_last) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_addr + C_ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (r_fall) begin
          w_advance   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      r_addr     <= '0;
      r_shreg    <= '0;
      r_bit      <= '0;
      r_row      <= '0;
      r_sdata    <= 1'b0;
      r_load     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_pat      <= 16'd0;
      r_rst_pend <= 1'b0;
    end else begin
      if (w_rd_en) r_addr <= w_rd_addr;
      if (w_start) begin
        r_busy <= 1'b1;
        r_bit  <= '0;
        r_row  <= '0;
      end
      if (w_load) begin
        r_sdata <= w_rd_data[C_MASK_DES_L-1];
        r_shreg <= {w_rd_data[C_MASK_DES_L-2:0], 1'b0};
        r_bit   <= '0;
        r_load  <= 1'b0;
      end
      if (w_next_row) r_row <= r_row + C_ROW_W'(1);
      if (w_shift) begin
        r_sdata <= r_shreg[C_MASK_DES_L-1];
        r_shreg <= {r_shreg[C_MASK_DES_L-2:0], 1'b0};
        r_bit   <= r_bit + C_BIT_W'(1);
        r_load  <= (r_bit == c_bit_pre);
      end
      if (w_finish || w_abort) begin
        r_sdata <= 1'b0;
        r_load  <= 1'b0;
        r_busy  <= 1'b0;
      end
      if (w_abort)      r_err <= 1'b1;
      else if (ERR_CLR) r_err <= 1'b0;
      // A reset request seen during a burst is held until the fall.
      if (w_advance) begin
        r_pat      <= (PAT_RST || r_rst_pend) ? 16'd0 : w_pat_next;
        r_rst_pend <= 1'b0;
      end else if (PAT_RST) begin
        if (r_state == ST_IDLE || r_state == ST_DONE) r_pat <= 16'd0;
        if (r_state != ST_IDLE) r_rst_pend <= 1'b1;
      end
    end
  end

  assign MASK_SDATA = r_sdata;
  assign MASK_LOAD  = r_load;
  assign PAT_IDX    = r_pat;
  assign BUSY       = r_busy;
  assign ERR_SHORT  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mask_pattern_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mask_pattern_streamer
//  Purpose  : Scoreboard bench for the mask pattern streamer.
//  Revision : 1.0
// ============================================================================
module tb_mask_pattern_streamer;

  localparam int L = 18;
  localparam int R = 160;

  logic        CLK_HS = 1'b0;
  logic        RESET = 1'b1, STREAM = 1'b0, PAT_RST = 1'b0, WR_EN = 1'b0, ERR_CLR = 1'b0;
  logic [31:0] NUM_PAT = 32'd3;
  logic [14:0] WR_ADDR = '0;
  logic [17:0] WR_DATA = '0;
  logic        MASK_SDATA, MASK_LOAD, BUSY, ERR_SHORT;
  logic [15:0] PAT_IDX;

  always #5 CLK_HS = ~CLK_HS;

  mask_pattern_streamer dut (
    .CLK_HS     (CLK_HS),
    .RESET      (RESET),
    .STREAM     (STREAM),
    .NUM_PAT    (NUM_PAT),
    .PAT_RST    (PAT_RST),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .ERR_CLR    (ERR_CLR),
    .MASK_SDATA (MASK_SDATA),
    .MASK_LOAD  (MASK_LOAD),
    .PAT_IDX    (PAT_IDX),
    .BUSY       (BUSY),
    .ERR_SHORT  (ERR_SHORT)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_pat = 0;
  logic [17:0] mdl [0:4][0:R-1];
  logic [17:0] q_exp [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] gen(input int p, input int r);
    if (p == 0) return 18'(r);
    return 18'((p * 40503 + r * 1021) ^ 32'h2A5A5);
  endfunction

  function automatic int next_pat(input int p, input logic [31:0] num);
    int eff;
    eff = (num == 0) ? 1 : (num > 128) ? 128 : int'(num);
    return (p + 1 >= eff) ? 0 : p + 1;
  endfunction

  // Monitor: rebuild row words from the serial stream, compare at MASK_LOAD.
  logic [17:0] acc = '0;
  int          nb = 0;
  bit          prev_busy = 1'b0;
  logic [17:0] e_word;

  always @(negedge CLK_HS) begin
    if (RESET) begin
      nb = 0;
      prev_busy = 1'b0;
    end else begin
      if (BUSY && prev_busy) begin
        acc = {acc[16:0], MASK_SDATA};
        nb++;
        if (MASK_LOAD || nb == L) begin
          check("load_present", 32'(MASK_LOAD), 32'd1);
          check("load_spacing", nb, L);
          if (MASK_LOAD) begin
            check("sb_nonempty", 32'(q_exp.size() > 0), 32'd1);
            if (q_exp.size() > 0) begin
              e_word = q_exp.pop_front();
              check("row_word", 32'(acc), 32'(e_word));
            end
          end
          nb = 0;
        end
      end else begin
        nb = 0;
      end
      prev_busy = BUSY;
    end
  end

  task automatic pulse_pat_rst();
    PAT_RST = 1'b1;
    @(negedge CLK_HS);
    PAT_RST = 1'b0;
  endtask

  task automatic clear_err();
    ERR_CLR = 1'b1;
    @(negedge CLK_HS);
    ERR_CLR = 1'b0;
    check("err_cleared", 32'(ERR_SHORT), 32'd0);
  endtask

  // One STREAM burst held high for 'hold' cycles; rst_at/wr_at place
  // PAT_RST and host-write pulses on a given cycle of the burst.
  task automatic burst(input int hold, input int pat, input int nwords,
                       input int rst_at, input int wr_at);
    check("pat_idx_start", 32'(PAT_IDX), pat);
    for (int w = 0; w < nwords; w++) q_exp.push_back(mdl[pat][w]);
    STREAM = 1'b1;
    for (int i = 1; i <= hold + 8; i++) begin
      @(negedge CLK_HS);
      PAT_RST = (i == rst_at);
      WR_EN   = (i == wr_at);
      if (i == hold) STREAM = 1'b0;
      if (i == 3) check("busy_before_fetch", 32'(BUSY), 32'd0);
      if (i == 4) check("busy_at_fetch", 32'(BUSY), 32'd1);
      if (nwords < R && i == hold + 4) begin
        check("short_err", 32'(ERR_SHORT), 32'd1);
        check("short_busy", 32'(BUSY), 32'd0);
        check("short_sdata", 32'(MASK_SDATA), 32'd0);
        check("short_load", 32'(MASK_LOAD), 32'd0);
      end
      if (nwords == R && hold > 2900 && i == 2900) begin
        check("done_busy", 32'(BUSY), 32'd0);
        check("done_sdata", 32'(MASK_SDATA), 32'd0);
        check("done_load", 32'(MASK_LOAD), 32'd0);
        check("done_pat_hold", 32'(PAT_IDX), pat);
      end
    end
    PAT_RST = 1'b0;
    WR_EN   = 1'b0;
    check("sb_drained", q_exp.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK_HS);
    check("rst_sdata", 32'(MASK_SDATA), 32'd0);
    check("rst_load", 32'(MASK_LOAD), 32'd0);
    check("rst_pat", 32'(PAT_IDX), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_err", 32'(ERR_SHORT), 32'd0);
    RESET = 1'b0;

    for (int p = 0; p < 5; p++) begin
      for (int r = 0; r < R; r++) begin
        mdl[p][r] = gen(p, r);
        WR_EN   = 1'b1;
        WR_ADDR = 15'(p * R + r);
        WR_DATA = mdl[p][r];
        @(negedge CLK_HS);
      end
    end
    WR_EN = 1'b0;
    @(negedge CLK_HS);

    // First full burst of pattern 0, NUM_PAT=3.
    burst(3000, 0, R, -1, -1);
    exp_pat = next_pat(0, NUM_PAT);
    check("pat_after_first", 32'(PAT_IDX), exp_pat);

    pulse_pat_rst();
    exp_pat = 0;
    check("pat_rst_idle", 32'(PAT_IDX), 32'd0);
    for (int k = 0; k < 4; k++) begin
      burst(3000, exp_pat, R, -1, -1);
      exp_pat = next_pat(exp_pat, NUM_PAT);
    end
    check("pat_after_rotation", 32'(PAT_IDX), exp_pat);

    // NUM_PAT=0 behaves as a single pattern.
    NUM_PAT = 32'd0;
    pulse_pat_rst();
    exp_pat = 0;
    for (int k = 0; k < 2; k++) begin
      burst(3000, exp_pat, R, -1, -1);
      exp_pat = next_pat(exp_pat, NUM_PAT);
    end
    check("pat_num0", 32'(PAT_IDX), exp_pat);

    // Short burst: 1000 bits shown, 55 complete rows.
    NUM_PAT = 32'd5;
    burst(1001, exp_pat, 55, -1, -1);
    exp_pat = next_pat(exp_pat, NUM_PAT);
    check("pat_after_short", 32'(PAT_IDX), exp_pat);
    clear_err();

    // PAT_RST mid-burst at pattern 2.
    burst(3000, exp_pat, R, -1, -1);
    exp_pat = next_pat(exp_pat, NUM_PAT);
    burst(3000, exp_pat, R, 1500, -1);
    exp_pat = 0;
    check("pat_rst_mid", 32'(PAT_IDX), exp_pat);

    // PAT_RST coincident with the internal fall of a short burst.
    burst(1001, exp_pat, 55, 1004, -1);
    exp_pat = 0;
    check("pat_rst_on_fall", 32'(PAT_IDX), exp_pat);
    clear_err();

    // Host write of pattern 1 row 5 in the cycle that row is fetched.
    burst(3000, exp_pat, R, -1, -1);
    exp_pat = next_pat(exp_pat, NUM_PAT);
    WR_ADDR = 15'(1 * R + 5);
    WR_DATA = 18'h3FFFF;
    burst(3000, 1, R, -1, 93);
    mdl[1][5] = 18'h3FFFF;
    exp_pat = next_pat(1, NUM_PAT);
    pulse_pat_rst();
    exp_pat = 0;
    burst(3000, exp_pat, R, -1, -1);
    exp_pat = next_pat(exp_pat, NUM_PAT);
    burst(3000, exp_pat, R, -1, -1);
    exp_pat = next_pat(exp_pat, NUM_PAT);

    // RESET mid-shift: 96 bits shown, 5 complete rows of pattern 2.
    check("pat_before_reset", 32'(PAT_IDX), exp_pat);
    for (int w = 0; w < 5; w++) q_exp.push_back(mdl[exp_pat][w]);
    STREAM = 1'b1;
    repeat (100) @(negedge CLK_HS);
    RESET  = 1'b1;
    STREAM = 1'b0;
    @(negedge CLK_HS);
    check("mid_rst_sdata", 32'(MASK_SDATA), 32'd0);
    check("mid_rst_load", 32'(MASK_LOAD), 32'd0);
    check("mid_rst_pat", 32'(PAT_IDX), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_err", 32'(ERR_SHORT), 32'd0);
    check("mid_rst_sb", q_exp.size(), 0);
    repeat (2) @(negedge CLK_HS);
    RESET = 1'b0;
    repeat (3) @(negedge CLK_HS);
    exp_pat = 0;
    burst(3000, exp_pat, R, -1, -1);
    exp_pat = next_pat(exp_pat, NUM_PAT);
    check("pat_after_reset_burst", 32'(PAT_IDX), exp_pat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
